// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: two requester ports plus the single DM port.
// The slave modport is the arbiter's view; master is the environment's view.
interface dm_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              c0_valid;
  logic              c0_ready;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic [3:0]        c0_be;
  logic              c0_rsp_valid;
  logic [DATA_W-1:0] c0_rsp_rdata;

  logic              c1_valid;
  logic              c1_ready;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic [3:0]        c1_be;
  logic              c1_rsp_valid;
  logic [DATA_W-1:0] c1_rsp_rdata;

  logic [ADDR_W-1:0] addressDM;
  logic              we;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;

  modport slave (
    input  c0_valid, c0_we, c0_addr, c0_wdata, c0_be,
    output c0_ready, c0_rsp_valid, c0_rsp_rdata,
    input  c1_valid, c1_we, c1_addr, c1_wdata, c1_be,
    output c1_ready, c1_rsp_valid, c1_rsp_rdata,
    output addressDM, we, wd,
    input  rd
  );

  modport master (
    output c0_valid, c0_we, c0_addr, c0_wdata, c0_be,
    input  c0_ready, c0_rsp_valid, c0_rsp_rdata,
    output c1_valid, c1_we, c1_addr, c1_wdata, c1_be,
    input  c1_ready, c1_rsp_valid, c1_rsp_rdata,
    input  addressDM, we, wd,
    output rd
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the data
// memory. Each accepted request runs as read, full write, or byte-enabled
// read-modify-write, and returns one registered response pulse.
module dm_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,   // asynchronous, active-low
  dm_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q;
  logic              gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              idle_c, gnt0_c, gnt1_c, accept_c;
  logic              full_c, partial_c, capture_c;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;
  logic [DATA_W-1:0] old_word, merged_word;

  // Round-robin: a lone requester wins, on a tie the port not granted last wins.
  assign idle_c   = (state_q == S_IDLE);
  assign gnt0_c   = bus.c0_valid & (~bus.c1_valid | last_grant_q);
  assign gnt1_c   = bus.c1_valid & (~bus.c0_valid | ~last_grant_q);
  assign accept_c = idle_c & (gnt0_c | gnt1_c);

  assign bus.c0_ready = idle_c & gnt0_c & rst;
  assign bus.c1_ready = idle_c & gnt1_c & rst;

  assign sel_we    = gnt1_c ? bus.c1_we    : bus.c0_we;
  assign sel_addr  = gnt1_c ? bus.c1_addr  : bus.c0_addr;
  assign sel_wdata = gnt1_c ? bus.c1_wdata : bus.c0_wdata;
  assign sel_be    = gnt1_c ? bus.c1_be    : bus.c0_be;

  // A write with no enabled bytes degenerates to a plain read.
  assign full_c    = we_q & (be_q == 4'hF);
  assign partial_c = we_q & (be_q != 4'h0) & (be_q != 4'hF);

  // Old word for merging lives in the granted port's response register.
  assign old_word = gnt_q ? rdata1_q : rdata0_q;

  // Byte merge: enabled lanes take new data, others keep the captured word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_byte
      assign merged_word[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  assign bus.addressDM = addr_q;
  assign bus.we        = (state_q == S_WRITE);
  assign bus.wd        = bus.we ? merged_word : '0;

  assign bus.c0_rsp_valid = (state_q == S_RESP) & ~gnt_q;
  assign bus.c1_rsp_valid = (state_q == S_RESP) &  gnt_q;

  // Capture in READ, or in WRITE for a full write (rd is still the old word).
  assign capture_c = (state_q == S_READ) | ((state_q == S_WRITE) & full_c);

  // Next-state sequencing of the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = (sel_we && sel_be == 4'hF) ? S_WRITE : S_READ;
        end
      end
      S_READ:  state_d = partial_c ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch and response data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= 4'h0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        last_grant_q <= gnt1_c;
        gnt_q        <= gnt1_c;
        addr_q       <= sel_addr;
        we_q         <= sel_we;
        wdata_q      <= sel_wdata;
        be_q         <= sel_be;
      end
      if (capture_c && !gnt_q) rdata0_q <= bus.rd;
      if (capture_c &&  gnt_q) rdata1_q <= bus.rd;
    end
  end

  assign bus.c0_rsp_rdata = rdata0_q;
  assign bus.c1_rsp_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 32-word data memory.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dm_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge, bench preload port.
  logic [31:0] mem [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  assign bus.rd = mem[bus.addressDM];
  always @(posedge clk) begin
    if (bus.we) mem[bus.addressDM] <= bus.wd;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.c0_valid = 0; bus.c0_we = 0; bus.c0_addr = '0; bus.c0_wdata = '0; bus.c0_be = '0;
    bus.c1_valid = 0; bus.c1_we = 0; bus.c1_addr = '0; bus.c1_wdata = '0; bus.c1_be = '0;
  endtask

  // Issues one request and monitors 8 cycles after accept (lat=0 means no accept/response).
  task automatic run_txn(input int port, input logic wr, input logic [4:0] a,
                         input logic [31:0] wdat, input logic [3:0] be,
                         output int lat, output int we_cyc, output int own_rsp,
                         output int other_rsp, output logic [31:0] rdat,
                         output logic [4:0] addr_seen);
    bit got;
    lat = 0; we_cyc = 0; own_rsp = 0; other_rsp = 0; rdat = '0; addr_seen = '0; got = 0;
    @(negedge clk);
    idle_inputs();
    if (port == 0) begin
      bus.c0_valid = 1; bus.c0_we = wr; bus.c0_addr = a; bus.c0_wdata = wdat; bus.c0_be = be;
    end else begin
      bus.c1_valid = 1; bus.c1_we = wr; bus.c1_addr = a; bus.c1_wdata = wdat; bus.c1_be = be;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      if ((port == 0 && bus.c0_ready) || (port == 1 && bus.c1_ready)) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    idle_inputs();
    if (got) begin
      for (int n = 1; n <= 8; n++) begin
        #1;
        if (n == 1) addr_seen = bus.addressDM;
        if (bus.we) we_cyc++;
        if ((port == 0 && bus.c1_rsp_valid) || (port == 1 && bus.c0_rsp_valid)) other_rsp++;
        if ((port == 0 && bus.c0_rsp_valid) || (port == 1 && bus.c1_rsp_valid)) begin
          own_rsp++;
          if (lat == 0) begin
            lat = n;
            rdat = (port == 0) ? bus.c0_rsp_rdata : bus.c1_rsp_rdata;
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.c0_valid = 1;
    rst = 0;
    #12;
    checks++;
    if (bus.c0_ready !== 1'b0 || bus.c1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", bus.c0_ready, bus.c1_ready);
    end
    checks++;
    if (bus.we !== 1'b0 || bus.wd !== 32'h0 || bus.addressDM !== 5'd0) begin
      errors++; $display("FAIL reset_dm: got we=%b wd=%h addr=%0d expected 0 0 0", bus.we, bus.wd, bus.addressDM);
    end
    checks++;
    if (bus.c0_rsp_valid !== 1'b0 || bus.c1_rsp_valid !== 1'b0 ||
        bus.c0_rsp_rdata !== 32'h0 || bus.c1_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b%b d0=%h d1=%h expected all 0",
                         bus.c0_rsp_valid, bus.c1_rsp_valid, bus.c0_rsp_rdata, bus.c1_rsp_rdata);
    end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (bus.c0_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.c0_ready);
    end
    bus.c0_valid = 0;
    $display("reset: done");
  endtask

  task automatic test_full_write_read();
    int lat, wec, own, oth; logic [31:0] rd; logic [4:0] as;
    preload(5'd0, 32'h1234_5678);
    run_txn(0, 1'b1, 5'd0, 32'hAAAA_AAAA, 4'hF, lat, wec, own, oth, rd, as);
    $display("full_write c0 addr0: lat=%0d we_cycles=%0d rsp=%0d rdata=%h", lat, wec, own, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL fw_latency: got %0d expected 2", lat); end
    checks++;
    if (wec !== 1 || own !== 1 || oth !== 0) begin
      errors++; $display("FAIL fw_pulses: got we=%0d own=%0d other=%0d expected 1 1 0", wec, own, oth);
    end
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL fw_prewrite_data: got %h expected 12345678", rd); end
    checks++;
    if (mem[0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL fw_mem: got %h expected aaaaaaaa", mem[0]); end

    run_txn(0, 1'b0, 5'd0, 32'h0, 4'h0, lat, wec, own, oth, rd, as);
    $display("read c0 addr0: lat=%0d rdata=%h", lat, rd);
    checks++;
    if (lat !== 2 || wec !== 0) begin errors++; $display("FAIL rd_latency: got lat=%0d we=%0d expected 2 0", lat, wec); end
    checks++;
    if (rd !== 32'hAAAA_AAAA) begin errors++; $display("FAIL rd_data: got %h expected aaaaaaaa", rd); end
  endtask

  task automatic test_partial_write();
    int lat, wec, own, oth; logic [31:0] rd; logic [4:0] as;
    preload(5'd1, 32'hBBBB_BBBB);
    run_txn(1, 1'b1, 5'd1, 32'h1122_3344, 4'b0101, lat, wec, own, oth, rd, as);
    $display("partial_write c1 addr1: lat=%0d we_cycles=%0d rdata=%h mem=%h", lat, wec, rd, mem[1]);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL pw_latency: got %0d expected 3", lat); end
    checks++;
    if (wec !== 1 || own !== 1 || oth !== 0) begin
      errors++; $display("FAIL pw_pulses: got we=%0d own=%0d other=%0d expected 1 1 0", wec, own, oth);
    end
    checks++;
    if (rd !== 32'hBBBB_BBBB) begin errors++; $display("FAIL pw_rdata: got %h expected bbbbbbbb", rd); end
    checks++;
    if (mem[1] !== 32'hBB22_BB44) begin errors++; $display("FAIL pw_mem: got %h expected bb22bb44", mem[1]); end
  endtask

  task automatic test_round_robin();
    int grants[6];
    int rsp_port[6];
    logic [31:0] rsp_data[6];
    int ng, nr, dual;
    logic [31:0] exp_d;
    ng = 0; nr = 0; dual = 0;
    for (int i = 0; i < 6; i++) begin grants[i] = 9; rsp_port[i] = 9; rsp_data[i] = '0; end
    preload(5'd2, 32'h2222_0002);
    preload(5'd3, 32'h3333_0003);
    @(negedge clk);
    idle_inputs();
    bus.c0_valid = 1; bus.c0_addr = 5'd2;
    bus.c1_valid = 1; bus.c1_addr = 5'd3;
    for (int cyc = 0; cyc < 60 && nr < 6; cyc++) begin
      #1;
      if (bus.c0_ready && bus.c1_ready) dual++;
      if (bus.c0_ready && ng < 6) begin grants[ng] = 0; ng++; end
      else if (bus.c1_ready && ng < 6) begin grants[ng] = 1; ng++; end
      if (bus.c0_rsp_valid && bus.c1_rsp_valid) dual++;
      if (bus.c0_rsp_valid && nr < 6) begin rsp_port[nr] = 0; rsp_data[nr] = bus.c0_rsp_rdata; nr++; end
      else if (bus.c1_rsp_valid && nr < 6) begin rsp_port[nr] = 1; rsp_data[nr] = bus.c1_rsp_rdata; nr++; end
      @(negedge clk);
      if (ng >= 6) begin bus.c0_valid = 0; bus.c1_valid = 0; end
    end
    idle_inputs();
    checks++;
    if (nr !== 6 || dual !== 0) begin
      errors++; $display("FAIL rr_count: got responses=%0d dual=%0d expected 6 0", nr, dual);
    end
    for (int i = 0; i < 6; i++) begin
      $display("rr grant %0d: port=%0d rsp_port=%0d rdata=%h", i, grants[i], rsp_port[i], rsp_data[i]);
      checks++;
      if (grants[i] !== (i % 2)) begin
        errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], i % 2);
      end
      exp_d = ((i % 2) == 0) ? 32'h2222_0002 : 32'h3333_0003;
      checks++;
      if (rsp_port[i] !== (i % 2) || rsp_data[i] !== exp_d) begin
        errors++; $display("FAIL rr_rsp%0d: got port=%0d data=%h expected %0d %h", i, rsp_port[i], rsp_data[i], i % 2, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit got;
    int rsp_seen, we_seen;
    got = 0; rsp_seen = 0; we_seen = 0;
    preload(5'd4, 32'hCCCC_CCCC);
    @(negedge clk);
    idle_inputs();
    bus.c0_valid = 1; bus.c0_we = 1; bus.c0_addr = 5'd4; bus.c0_wdata = 32'h5566_7788; bus.c0_be = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.c0_ready) begin got = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    idle_inputs();
    rst = 0;
    #1;
    checks++;
    if (!got || bus.we !== 1'b0) begin
      errors++; $display("FAIL midrst_we: got accepted=%0d we=%b expected 1 0", got, bus.we);
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 2) rst = 1;
      #1;
      if (bus.we) we_seen++;
      if (bus.c0_rsp_valid || bus.c1_rsp_valid) rsp_seen++;
    end
    $display("reset_mid_op c0 addr4: we_seen=%0d rsp_seen=%0d mem=%h", we_seen, rsp_seen, mem[4]);
    checks++;
    if (we_seen !== 0 || rsp_seen !== 0) begin
      errors++; $display("FAIL midrst_no_activity: got we=%0d rsp=%0d expected 0 0", we_seen, rsp_seen);
    end
    checks++;
    if (mem[4] !== 32'hCCCC_CCCC) begin errors++; $display("FAIL midrst_mem: got %h expected cccccccc", mem[4]); end
    checks++;
    if (bus.c0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", bus.c0_rsp_rdata); end
  endtask

  task automatic test_zero_be_top_addr();
    int lat, wec, own, oth; logic [31:0] rd; logic [4:0] as;
    preload(5'd31, 32'h5A5A_0F1F);
    run_txn(1, 1'b1, 5'd31, 32'hFFFF_FFFF, 4'h0, lat, wec, own, oth, rd, as);
    $display("zero_be c1 addr31: lat=%0d we_cycles=%0d addr=%0d rdata=%h", lat, wec, as, rd);
    checks++;
    if (wec !== 0) begin errors++; $display("FAIL zbe_we: got %0d expected 0", wec); end
    checks++;
    if (lat !== 2 || own !== 1 || oth !== 0) begin
      errors++; $display("FAIL zbe_rsp: got lat=%0d own=%0d other=%0d expected 2 1 0", lat, own, oth);
    end
    checks++;
    if (rd !== 32'h5A5A_0F1F || mem[31] !== 32'h5A5A_0F1F) begin
      errors++; $display("FAIL zbe_data: got rdata=%h mem=%h expected 5a5a0f1f", rd, mem[31]);
    end
    checks++;
    if (as !== 5'd31) begin errors++; $display("FAIL zbe_addr: got %0d expected 31", as); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_round_robin();
    test_reset_mid_op();
    test_zero_be_top_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
